// File: rtl/aes_encipher_core_p.sv
// Iterative AES encipher core: runs every round, reads round keys from an external store and shares 1/2/4 external S-box lanes.
// Define AES_ENC_ABORT_EN to add the abort input that cancels a block in progress.
module aes_encipher_core_p #(
    parameter int unsigned SBOX_WORDS = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      next,
    input  logic                      keylen,
`ifdef AES_ENC_ABORT_EN
    input  logic                      abort,
`endif
    output logic [3:0]                round,
    input  logic [127:0]              round_key,
    output logic [32*SBOX_WORDS-1:0]  sboxw,
    input  logic [32*SBOX_WORDS-1:0]  new_sboxw,
    input  logic [127:0]              block,
    output logic [127:0]              new_block,
    output logic                      ready
);

    localparam int unsigned LANE_W     = 32 * SBOX_WORDS;
    localparam int unsigned SUB_CYCLES = 4 / SBOX_WORDS;
    localparam int unsigned CNT_W      = 2;
    localparam logic [3:0]  NR_128     = 4'd10;
    localparam logic [3:0]  NR_256     = 4'd14;

    generate
        if (SBOX_WORDS != 1 && SBOX_WORDS != 2 && SBOX_WORDS != 4) begin : g_bad_sbox_words
            $error("aes_encipher_core_p: SBOX_WORDS must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        RND  = 2'd2
    } state_t;

    state_t             state;
    logic [127:0]       st;
    logic [3:0]         nr_reg;
    logic [CNT_W-1:0]   sub_cnt;

    logic [127:0]       st_rot;
    logic [127:0]       sr;
    logic [127:0]       mc;
    logic [127:0]       rnd_result;
    logic               last_round;
    logic               abort_req;

`ifdef AES_ENC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r of the output takes its byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c + row) % 4) - 8*row -: 8];
            end
        end
        return r;
    endfunction

    // S-box lanes always see the top of the state; SubBytes rotates results in at the bottom.
    assign sboxw = st[127 -: LANE_W];

    generate
        if (SBOX_WORDS == 4) begin : g_rot_full
            assign st_rot = new_sboxw;
        end else begin : g_rot_part
            assign st_rot = {st[127-LANE_W:0], new_sboxw};
        end
    endgenerate

    always_comb begin
        sr         = shift_rows(st);
        mc         = {mix_word(sr[127:96]), mix_word(sr[95:64]),
                      mix_word(sr[63:32]),  mix_word(sr[31:0])};
        last_round = (round == nr_reg);
        rnd_result = (last_round ? sr : mc) ^ round_key;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            st        <= '0;
            round     <= '0;
            nr_reg    <= NR_128;
            sub_cnt   <= '0;
            ready     <= 1'b1;
            new_block <= '0;
        end else if (abort_req && state != IDLE) begin
            state   <= IDLE;
            round   <= '0;
            sub_cnt <= '0;
            ready   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (next) begin
                        st      <= block ^ round_key;
                        round   <= 4'd1;
                        nr_reg  <= keylen ? NR_256 : NR_128;
                        sub_cnt <= '0;
                        ready   <= 1'b0;
                        state   <= SUB;
                    end
                end
                SUB: begin
                    st <= st_rot;
                    if (sub_cnt == CNT_W'(SUB_CYCLES - 1)) begin
                        sub_cnt <= '0;
                        state   <= RND;
                    end else begin
                        sub_cnt <= sub_cnt + CNT_W'(1);
                    end
                end
                RND: begin
                    if (last_round) begin
                        new_block <= rnd_result;
                        ready     <= 1'b1;
                        round     <= '0;
                        state     <= IDLE;
                    end else begin
                        st    <= rnd_result;
                        round <= round + 4'd1;
                        state <= SUB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encipher_core_p.sv
// Directed FIPS-197 vectors against three core instances (1, 4 and 2 S-box lanes) with a bench key store and S-box.
`timescale 1ns/1ps
module tb_aes_encipher_core_p;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         keylen;
    logic [127:0] block;
    logic [2:0]   next_v;
    logic [2:0]   rdy;
    logic [3:0]   rnd  [3];
    logic [127:0] rkey [3];
    logic [127:0] nb   [3];
    logic [31:0]  sw0, nsw0;
    logic [127:0] sw1, nsw1;
    logic [63:0]  sw2, nsw2;
`ifdef AES_ENC_ABORT_EN
    logic         abort;
`endif

    logic [127:0] rk128 [15];
    logic [127:0] rk256 [15];
    logic         ks_sel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, base, e;
        inv = 8'h01; base = a; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign nsw0 = sub_word(sw0);
    assign nsw1 = {sub_word(sw1[127:96]), sub_word(sw1[95:64]), sub_word(sw1[63:32]), sub_word(sw1[31:0])};
    assign nsw2 = {sub_word(sw2[63:32]), sub_word(sw2[31:0])};

    assign rkey[0] = ks_sel ? rk256[rnd[0]] : rk128[rnd[0]];
    assign rkey[1] = ks_sel ? rk256[rnd[1]] : rk128[rnd[1]];
    assign rkey[2] = ks_sel ? rk256[rnd[2]] : rk128[rnd[2]];

    aes_encipher_core_p #(.SBOX_WORDS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .next(next_v[0]), .keylen(keylen),
`ifdef AES_ENC_ABORT_EN
        .abort(abort),
`endif
        .round(rnd[0]), .round_key(rkey[0]), .sboxw(sw0), .new_sboxw(nsw0),
        .block(block), .new_block(nb[0]), .ready(rdy[0])
    );

    aes_encipher_core_p #(.SBOX_WORDS(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .next(next_v[1]), .keylen(keylen),
`ifdef AES_ENC_ABORT_EN
        .abort(abort),
`endif
        .round(rnd[1]), .round_key(rkey[1]), .sboxw(sw1), .new_sboxw(nsw1),
        .block(block), .new_block(nb[1]), .ready(rdy[1])
    );

    aes_encipher_core_p #(.SBOX_WORDS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .next(next_v[2]), .keylen(keylen),
`ifdef AES_ENC_ABORT_EN
        .abort(abort),
`endif
        .round(rnd[2]), .round_key(rkey[2]), .sboxw(sw2), .new_sboxw(nsw2),
        .block(block), .new_block(nb[2]), .ready(rdy[2])
    );

    // FIPS-197 key expansion into the 128- or 256-bit key store; a 128-bit key sits in key[255:128].
    task automatic expand(input logic [255:0] key, input bit is256);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nw;
        nk = is256 ? 8 : 4;
        nw = is256 ? 60 : 44;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < nw / 4; r++) begin
            if (is256) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else       rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Ends 1 ns after the edge that samples next (edge 0).
    task automatic launch(input int d, input logic [127:0] pt, input logic kl);
        @(negedge clk);
        block     = pt;
        keylen    = kl;
        next_v[d] = 1'b1;
        @(posedge clk); #1;
        next_v[d] = 1'b0;
    endtask

    // Latency in edges from the sampling edge; -1 when ready never rises.
    task automatic wait_ready(input int d, input int elapsed, output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        for (int i = elapsed + 1; i <= 200 && !done; i++) begin
            @(posedge clk); #1;
            if (rdy[d]) begin
                lat  = i;
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        next_v  = 3'b000;
        keylen  = 1'b0;
        block   = '0;
        ks_sel  = 1'b0;
`ifdef AES_ENC_ABORT_EN
        abort   = 1'b0;
`endif
        #12;
        checks++;
        if (rdy !== 3'b111) begin
            failures++; $display("FAIL reset_ready got=%b exp=111", rdy);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rnd[d] !== 4'd0) begin
                failures++; $display("FAIL reset_round%0d got=%0d exp=0", d, rnd[d]);
            end
            checks++;
            if (nb[d] !== 128'h0) begin
                failures++; $display("FAIL reset_new_block%0d got=%h exp=0", d, nb[d]);
            end
        end
        checks++;
        if (sw0 !== 32'h0 || sw1 !== 128'h0) begin
            failures++; $display("FAIL reset_sboxw got=%h/%h exp=0", sw0, sw1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cycles(3);
        checks++;
        if (rdy !== 3'b111 || rnd[0] !== 4'd0) begin
            failures++; $display("FAIL idle_hold got=%b/%0d exp=111/0", rdy, rnd[0]);
        end
    endtask

    task automatic test_fips_b();
        int lat;
        expand({KEY_B, 128'h0}, 1'b0);
        ks_sel = 1'b0;
        launch(0, PT_B, 1'b0);
        checks++;
        if (rdy[0] !== 1'b0 || rnd[0] !== 4'd1) begin
            failures++; $display("FAIL b_start got=%b/%0d exp=0/1", rdy[0], rnd[0]);
        end
        wait_ready(0, 0, lat);
        checks++;
        if (lat !== 50) begin
            failures++; $display("FAIL b_latency got=%0d exp=50", lat);
        end
        checks++;
        if (nb[0] !== CT_B) begin
            failures++; $display("FAIL b_cipher got=%h exp=%h", nb[0], CT_B);
        end
    endtask

    task automatic test_fips_c1();
        logic [3:0] exp_round;
        expand({KEY_C1, 128'h0}, 1'b0);
        ks_sel = 1'b0;
        launch(1, PT_C, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            exp_round = (k == 20) ? 4'd0 : 4'(k / 2 + 1);
            checks++;
            if (rnd[1] !== exp_round || rdy[1] !== (k == 20)) begin
                failures++;
                $display("FAIL c1_round_edge%0d got=%0d/%b exp=%0d/%b", k, rnd[1], rdy[1], exp_round, k == 20);
            end
            if (k < 20) cycles(1);
        end
        checks++;
        if (nb[1] !== CT_C1) begin
            failures++; $display("FAIL c1_cipher got=%h exp=%h", nb[1], CT_C1);
        end
    endtask

    task automatic test_fips_c3();
        int lat;
        expand(KEY_C3, 1'b1);
        ks_sel = 1'b1;
        launch(2, PT_C, 1'b1);
        wait_ready(2, 0, lat);
        checks++;
        if (lat !== 42) begin
            failures++; $display("FAIL c3_latency got=%0d exp=42", lat);
        end
        checks++;
        if (nb[2] !== CT_C3) begin
            failures++; $display("FAIL c3_cipher got=%h exp=%h", nb[2], CT_C3);
        end
    endtask

    task automatic test_busy();
        int lat;
        expand({KEY_B, 128'h0}, 1'b0);
        ks_sel = 1'b0;
        launch(0, PT_B, 1'b0);
        cycles(10);
        next_v[0] = 1'b1;
        block     = 128'hdeadbeefcafef00d0123456789abcdef;
        keylen    = 1'b1;
        cycles(3);
        next_v[0] = 1'b0;
        checks++;
        if (rdy[0] !== 1'b0) begin
            failures++; $display("FAIL busy_ready got=%b exp=0", rdy[0]);
        end
        wait_ready(0, 13, lat);
        checks++;
        if (lat !== 50) begin
            failures++; $display("FAIL busy_latency got=%0d exp=50", lat);
        end
        checks++;
        if (nb[0] !== CT_B) begin
            failures++; $display("FAIL busy_cipher got=%h exp=%h", nb[0], CT_B);
        end
    endtask

    // AES-128 C.1 then AES-256 C.3 on the same plaintext; round key 0 is identical in both stores.
    task automatic test_back_to_back();
        int lat;
        expand({KEY_C1, 128'h0}, 1'b0);
        expand(KEY_C3, 1'b1);
        ks_sel = 1'b0;
        launch(2, PT_C, 1'b0);
        wait_ready(2, 0, lat);
        checks++;
        if (lat !== 30 || nb[2] !== CT_C1) begin
            failures++; $display("FAIL b2b_first got=%0d/%h exp=30/%h", lat, nb[2], CT_C1);
        end
        next_v[2] = 1'b1;
        keylen    = 1'b1;
        ks_sel    = 1'b1;
        @(posedge clk); #1;
        next_v[2] = 1'b0;
        checks++;
        if (rdy[2] !== 1'b0 || nb[2] !== CT_C1) begin
            failures++; $display("FAIL b2b_restart got=%b/%h exp=0/%h", rdy[2], nb[2], CT_C1);
        end
        wait_ready(2, 0, lat);
        checks++;
        if (lat !== 42) begin
            failures++; $display("FAIL b2b_latency got=%0d exp=42", lat);
        end
        checks++;
        if (nb[2] !== CT_C3) begin
            failures++; $display("FAIL b2b_second got=%h exp=%h", nb[2], CT_C3);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        expand({KEY_B, 128'h0}, 1'b0);
        ks_sel = 1'b0;
        launch(0, PT_B, 1'b0);
        cycles(17);
        reset_n = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || rnd[0] !== 4'd0) begin
            failures++; $display("FAIL midreset_state got=%b/%0d exp=1/0", rdy[0], rnd[0]);
        end
        checks++;
        if (nb[0] !== 128'h0 || nb[2] !== 128'h0) begin
            failures++; $display("FAIL midreset_block got=%h/%h exp=0", nb[0], nb[2]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        launch(0, PT_B, 1'b0);
        wait_ready(0, 0, lat);
        checks++;
        if (lat !== 50 || nb[0] !== CT_B) begin
            failures++; $display("FAIL midreset_rerun got=%0d/%h exp=50/%h", lat, nb[0], CT_B);
        end
    endtask

`ifdef AES_ENC_ABORT_EN
    task automatic test_abort();
        int lat;
        launch(0, PT_C, 1'b0);
        cycles(9);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        checks++;
        if (rdy[0] !== 1'b1 || rnd[0] !== 4'd0) begin
            failures++; $display("FAIL abort_state got=%b/%0d exp=1/0", rdy[0], rnd[0]);
        end
        checks++;
        if (nb[0] !== CT_B) begin
            failures++; $display("FAIL abort_block got=%h exp=%h", nb[0], CT_B);
        end
        abort = 1'b1;
        cycles(2);
        abort = 1'b0;
        checks++;
        if (rdy[0] !== 1'b1 || rnd[0] !== 4'd0 || nb[0] !== CT_B) begin
            failures++; $display("FAIL abort_idle got=%b/%0d/%h exp=1/0/%h", rdy[0], rnd[0], nb[0], CT_B);
        end
        launch(0, PT_B, 1'b0);
        wait_ready(0, 0, lat);
        checks++;
        if (lat !== 50 || nb[0] !== CT_B) begin
            failures++; $display("FAIL abort_rerun got=%0d/%h exp=50/%h", lat, nb[0], CT_B);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_fips_c3();
        test_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_ENC_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_encipher_core_p.md
Name: aes_encipher_core_p

Overview:
Parametrised, iterative AES encipher core, the successor of the single-round encipher block. It runs all rounds: initial AddRoundKey, Nr-1 full rounds, and a final round without MixColumns. The core drives a round index to an external key store and time-shares 1, 2 or 4 external 32-bit S-box lanes. It supports AES-128 (10 rounds) and AES-256 (14 rounds), selected per block.

Parameters:
- SBOX_WORDS, 1, number of 32-bit S-box lanes used per cycle; legal values are 1, 2 and 4. Any other value is an elaboration error.
- SUB_CYCLES, 4/SBOX_WORDS, derived localparam: SubBytes cycles per round. Not overridable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- next  in  1  start request; sampled only in IDLE.
- keylen  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled with accepted next.
- round  out  4  current round index; selects round_key.
- round_key  in  128  key for `round`; combinational from `round`, valid in the same cycle.
- sboxw  out  32*SBOX_WORDS  words to S-box lanes; lane i = bits [32*(SBOX_WORDS-i)-1 -: 32].
- new_sboxw  in  32*SBOX_WORDS  combinational S-box results, same lane order.
- block  in  128  plaintext; sampled with accepted next.
- new_block  out  128  ciphertext; holds until the next completion.
- ready  out  1  high = idle, and new_block is valid once at least one block has completed.

Behaviour:
- Reset is asynchronous and active-low. Reset values: state=IDLE, round=0, ready=1, new_block=0, sboxw=0 (internal state cleared), round counter=0, nr_reg=10.
- Byte order: column c = block[127-32c -: 32]. Row 0 of each column is the MSB byte.
- States:
  - IDLE: round=0. When next=1 at a clock edge: st<=block^round_key, round<=1, nr_reg<=keylen?14:10, ready<=0, sub counter<=0, go to SUB. next=0 keeps the core in IDLE.
  - SUB: sboxw=st[127 -: 32*SBOX_WORDS]. Each cycle: st<={st[127-32*SBOX_WORDS:0], new_sboxw} (rotate left by the lane width), sub counter++. After SUB_CYCLES cycles the words are back in column order; go to RND.
  - RND (one cycle): ShiftRows (row r rotates left by r columns), then MixColumns if round!=nr_reg, then XOR with round_key.
    - If round==nr_reg: new_block<=result, ready<=1, round<=0, go to IDLE.
    - Else: st<=result, round<=round+1, go to SUB.
- Latency, counted from the edge that samples next to the edge where ready rises and new_block is valid: Nr*(SUB_CYCLES+1) cycles.
  - SBOX_WORDS=1: 50 cycles (AES-128), 70 cycles (AES-256).
  - SBOX_WORDS=4: 20 cycles (AES-128), 28 cycles (AES-256).
- Back-to-back: next may be asserted in the first cycle ready=1. The new block starts and ready drops after one cycle high.
- next, keylen and block changes while busy are ignored. No queuing.
- sboxw outside SUB: don't care but stable (drives the st top word).
- Reset mid-operation: immediate return to reset values; the partial result is discarded and new_block returns to 0.
- round never exceeds nr_reg; 4-bit width is sufficient (max 14).

Optional Feature:
AES_ENC_ABORT_EN.
- Defined: adds input `abort` (1 bit). When abort=1 in SUB or RND: next edge goes to IDLE, round<=0, ready<=1, new_block unchanged, no ciphertext written. If abort and the final RND coincide, abort wins. abort is ignored in IDLE.
- Undefined: no abort port. A started block always runs to completion.

Test Plan:
- FIPS-197 App. B, SBOX_WORDS=1, keylen=0: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c (round keys from bench model) -> ready rises 50 cycles after next, new_block=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.1, SBOX_WORDS=4: pt 00112233445566778899aabbccddeeff, key 000102…0f -> new_block=69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles; round steps 0→1…10→0.
- FIPS-197 C.3 AES-256, SBOX_WORDS=2, keylen=1, key 000102…1f -> new_block=8ea2b7ca516745bfeafc49904b496089 after 42 cycles.
- Busy robustness: pulse next and change block/keylen mid-operation -> result is still the first vector. Back-to-back next on first ready cycle -> both ciphertexts correct.
- Reset at cycle 17 of a block -> ready=1, round=0, new_block=0 immediately. A following App. B run is correct.
- With AES_ENC_ABORT_EN: abort at cycle 10 -> ready=1 next cycle, new_block keeps the prior ciphertext. An abort pulse in IDLE has no effect.
